// File: rtl/fir_mac_sequencer_pkg.sv
// Shared definitions for the symmetric-FIR blocks: FSM state encoding and helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fir_mac_sequencer_pkg;

  // Encoding is fixed so other FIR blocks and debug views can decode the state.
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } fir_state_t;

  // Ceiling log2 for deriving address widths from tap counts.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_ptr_wrap.sv
// Modular pointer add/sub: res = (ptr +/- off) mod N_TAPS, with ptr and off already < N_TAPS.
// Latency: combinational.
// Backpressure: none.
module fir_mac_sequencer_ptr_wrap #(
  parameter int N_TAPS = 8,
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0] ptr,
  input  logic [ADDR_W-1:0] off,
  input  logic              sub,
  output logic [ADDR_W-1:0] res
);

  // Modulus in the extended width for the add-side compare, and truncated for the
  // wrap correction (arithmetic mod 2^ADDR_W gives the right answer since res < N_TAPS).
  localparam logic [ADDR_W:0]   MOD_X = (ADDR_W+1)'(N_TAPS);
  localparam logic [ADDR_W-1:0] MOD_W = ADDR_W'(N_TAPS);

  logic [ADDR_W:0] sum_x;

  // Compare-and-wrap instead of a divider: one subtract/compare per direction.
  always_comb begin
    sum_x = {1'b0, ptr} + {1'b0, off};
    res   = '0;
    if (sub) begin
      res = (ptr >= off) ? (ptr - off) : (ptr - off + MOD_W);
    end else begin
      res = (sum_x >= MOD_X) ? (sum_x[ADDR_W-1:0] - MOD_W) : sum_x[ADDR_W-1:0];
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Control FSM for a symmetric FIR: buffer flush/write, tap-pair and ROM addressing, MAC clear, output register.
// Latency: accept cycle to y_valid cycle is P+2 cycles, P = (N_TAPS+1)/2; one sample per P+2 cycles.
// Backpressure: sample_ready only in IDLE; upstream holds sample_valid. Optional FIR_SEQ_OVERRUN_EN adds sticky overrun.
module fir_mac_sequencer
  import fir_mac_sequencer_pkg::*;
#(
  parameter int N_TAPS        = 8,
  parameter int ADDR_W        = 3,
  parameter int ROM_AW        = 2,
  parameter int WIDTH_MAC_OUT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  output logic                     wr_en,
  output logic                     wr_zero,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [ADDR_W-1:0]        rd_addr_a,
  output logic [ADDR_W-1:0]        rd_addr_b,
  output logic                     mid_tap,
  output logic [ROM_AW-1:0]        rom_addr,
  output logic                     mac_clr,
  input  logic [WIDTH_MAC_OUT-1:0] mac_out,
  output logic [WIDTH_MAC_OUT-1:0] y_out,
  output logic                     y_valid,
  output logic                     busy
`ifdef FIR_SEQ_OVERRUN_EN
  ,
  output logic                     overrun
`endif
);

  localparam int P = (N_TAPS + 1) / 2;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_TAPS - 1);
  localparam logic [ADDR_W-1:0] LAST_K   = ADDR_W'(P - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam bit                ODD      = (N_TAPS % 2) == 1;

  fir_state_t state_q, state_d;
  // idx is the flush address during INIT and the tap-pair index k during ACCUM.
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_inc;
  logic [ADDR_W-1:0] k_plus1;

  assign k_plus1 = idx_q + ONE;

  // Newer tap of the pair: base - k.
  fir_mac_sequencer_ptr_wrap #(.N_TAPS(N_TAPS), .ADDR_W(ADDR_W)) u_wrap_a (
    .ptr (base_q),
    .off (idx_q),
    .sub (1'b1),
    .res (rd_addr_a)
  );

  // Mirror tap: base + 1 + k, i.e. base - (N_TAPS-1-k).
  fir_mac_sequencer_ptr_wrap #(.N_TAPS(N_TAPS), .ADDR_W(ADDR_W)) u_wrap_b (
    .ptr (base_q),
    .off (k_plus1),
    .sub (1'b0),
    .res (rd_addr_b)
  );

  // Circular-buffer write pointer advance.
  fir_mac_sequencer_ptr_wrap #(.N_TAPS(N_TAPS), .ADDR_W(ADDR_W)) u_wrap_wr (
    .ptr (wr_ptr_q),
    .off (ONE),
    .sub (1'b0),
    .res (wr_ptr_inc)
  );

  assign rom_addr = idx_q[ROM_AW-1:0];
  assign busy     = (state_q != ST_IDLE);

  // State and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      idx_q    <= '0;
      base_q   <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    base_d       = base_q;
    wr_ptr_d     = wr_ptr_q;
    sample_ready = 1'b0;
    wr_en        = 1'b0;
    wr_zero      = 1'b0;
    wr_addr      = '0;
    mac_clr      = 1'b0;
    mid_tap      = 1'b0;
    case (state_q)
      ST_INIT: begin
        // Write strobe held off while reset is asserted so the buffer is not
        // scribbled on before the flush actually runs.
        wr_en   = rst_n;
        wr_zero = 1'b1;
        wr_addr = idx_q;
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ONE;
        end
      end
      ST_IDLE: begin
        sample_ready = 1'b1;
        if (sample_valid) begin
          wr_en    = 1'b1;
          wr_addr  = wr_ptr_q;
          base_d   = wr_ptr_q;
          wr_ptr_d = wr_ptr_inc;
          idx_d    = '0;
          state_d  = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        mac_clr = (idx_q == '0);
        // Odd length: last pair is the centre tap, both read ports hit the same word.
        mid_tap = ODD && (idx_q == LAST_K);
        if (idx_q == LAST_K) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Capture the finished MAC sum; y_valid lands in the following IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_out   <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        y_out <= mac_out;
      end
    end
  end

`ifdef FIR_SEQ_OVERRUN_EN
  // Sticky flag: upstream offered a sample while a result was still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (sample_valid && busy && (state_q != ST_INIT)) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: two instances (N_TAPS=8 and N_TAPS=5) each with a buffer/ROM/MAC model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fir_mac_sequencer;

  typedef struct packed {
    logic [7:0] smp;
    logic [7:0] y;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       sv       [2];
  logic [7:0] smp      [2];
  logic       rdy      [2];
  logic       wr_en_w  [2];
  logic       wr_zero_w[2];
  logic [2:0] wa_w     [2];
  logic [2:0] ra_w     [2];
  logic [2:0] rb_w     [2];
  logic       mid_w    [2];
  logic [1:0] rom_w    [2];
  logic       clr_w    [2];
  logic [7:0] mac_w    [2];
  logic [7:0] y_w      [2];
  logic       yv_w     [2];
  logic       busy_w   [2];
`ifdef FIR_SEQ_OVERRUN_EN
  logic       ovr_w    [2];
`endif

  logic [7:0] mem  [2][8];
  logic [7:0] h    [2][4];
  logic [7:0] acc  [2];
  logic [7:0] prod [2];
  logic [2:0] exp_wp [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fir_mac_sequencer #(.N_TAPS(8), .ADDR_W(3), .ROM_AW(2), .WIDTH_MAC_OUT(8)) dut8 (
    .clk (clk), .rst_n (rst_n),
    .sample_valid (sv[0]), .sample_ready (rdy[0]),
    .wr_en (wr_en_w[0]), .wr_zero (wr_zero_w[0]), .wr_addr (wa_w[0]),
    .rd_addr_a (ra_w[0]), .rd_addr_b (rb_w[0]), .mid_tap (mid_w[0]),
    .rom_addr (rom_w[0]), .mac_clr (clr_w[0]), .mac_out (mac_w[0]),
    .y_out (y_w[0]), .y_valid (yv_w[0]), .busy (busy_w[0])
`ifdef FIR_SEQ_OVERRUN_EN
    , .overrun (ovr_w[0])
`endif
  );

  fir_mac_sequencer #(.N_TAPS(5), .ADDR_W(3), .ROM_AW(2), .WIDTH_MAC_OUT(8)) dut5 (
    .clk (clk), .rst_n (rst_n),
    .sample_valid (sv[1]), .sample_ready (rdy[1]),
    .wr_en (wr_en_w[1]), .wr_zero (wr_zero_w[1]), .wr_addr (wa_w[1]),
    .rd_addr_a (ra_w[1]), .rd_addr_b (rb_w[1]), .mid_tap (mid_w[1]),
    .rom_addr (rom_w[1]), .mac_clr (clr_w[1]), .mac_out (mac_w[1]),
    .y_out (y_w[1]), .y_valid (yv_w[1]), .busy (busy_w[1])
`ifdef FIR_SEQ_OVERRUN_EN
    , .overrun (ovr_w[1])
`endif
  );

  assign mac_w[0] = acc[0];
  assign mac_w[1] = acc[1];

  // Pre-adder and multiplier of the external datapath.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      prod[d] = (mem[d][ra_w[d]] + (mid_w[d] ? 8'd0 : mem[d][rb_w[d]])) * h[d][rom_w[d]];
    end
  end

  // Sample buffer and accumulator of the external datapath.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wr_en_w[d]) mem[d][wa_w[d]] <= wr_zero_w[d] ? 8'd0 : smp[d];
      acc[d] <= clr_w[d] ? prod[d] : acc[d] + prod[d];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called right after rst_n rises at a falling edge: checks the flush on both instances.
  task automatic init_seq();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("init_dut8", 32'({wr_en_w[0], wr_zero_w[0], rdy[0], yv_w[0], wa_w[0]}),
          32'({4'b1100, 3'(i)}));
      if (i < 5)
        chk("init_dut5", 32'({wr_en_w[1], wr_zero_w[1], rdy[1], yv_w[1], wa_w[1]}),
            32'({4'b1100, 3'(i)}));
      else
        chk("init_dut5_idle", 32'({wr_en_w[1], rdy[1], yv_w[1]}), 32'(3'b010));
      @(negedge clk);
    end
    #1;
    chk("init_done_ready", 32'({rdy[0], busy_w[0], rdy[1], busy_w[1]}), 32'(4'b1010));
    exp_wp[0] = 3'd0;
    exp_wp[1] = 3'd0;
  endtask

  // One transaction: offer s, check accept, every ACCUM cycle, DONE, then y_out.
  // Entered and left shortly after a falling edge.
  task automatic send(input int d, input logic [7:0] s, input logic [7:0] ey, input bit hold);
    int n, p, base, ea, eb;
    bit got;
    n = (d == 0) ? 8 : 5;
    p = (n + 1) / 2;
    smp[d] = s;
    sv[d] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 16 && !got; c++) begin
      #1;
      if (rdy[d]) got = 1'b1;
      else @(negedge clk);
    end
    chk("accept", 32'(rdy[d]), 32'd1);
    if (!got) return;
    chk("accept_write", 32'({wr_en_w[d], wr_zero_w[d], wa_w[d]}), 32'({2'b10, exp_wp[d]}));
    base = int'(exp_wp[d]);
    exp_wp[d] = 3'((base + 1) % n);
    @(negedge clk);
    if (!hold) sv[d] = 1'b0;
    for (int k = 0; k < p; k++) begin
      #1;
      ea = (base + n - k) % n;
      eb = (base + 1 + k) % n;
      chk("accum_ctl",
          32'({rdy[d], wr_en_w[d], yv_w[d], clr_w[d], mid_w[d], ra_w[d], rb_w[d], rom_w[d]}),
          32'({3'b000, (k == 0), ((n % 2 == 1) && (k == p - 1)), 3'(ea), 3'(eb), 2'(k)}));
      if ((n % 2 == 1) && (k == p - 1)) chk("mid_pair_equal", 32'(ra_w[d]), 32'(rb_w[d]));
      @(negedge clk);
    end
    #1;
    chk("done_ctl", 32'({busy_w[d], rdy[d], yv_w[d], wr_en_w[d]}), 32'(4'b1000));
    @(negedge clk);
    #1;
    chk("y_valid", 32'({yv_w[d], busy_w[d], rdy[d]}), 32'(3'b101));
    chk("y_out", 32'(y_w[d]), 32'(ey));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t t1[9];
    vec_t t2[6];
    // N_TAPS=8, h={1,2,3,4}: impulse response mirrors the coefficients.
    t1 = '{'{8'd1, 8'd1}, '{8'd0, 8'd2}, '{8'd0, 8'd3}, '{8'd0, 8'd4}, '{8'd0, 8'd4},
           '{8'd0, 8'd3}, '{8'd0, 8'd2}, '{8'd0, 8'd1}, '{8'd0, 8'd0}};
    // N_TAPS=5, h={1,2,3}: centre tap used once.
    t2 = '{'{8'd1, 8'd1}, '{8'd0, 8'd2}, '{8'd0, 8'd3}, '{8'd0, 8'd2}, '{8'd0, 8'd1},
           '{8'd0, 8'd0}};
    for (int i = 0; i < 4; i++) begin
      h[0][i] = 8'(i + 1);
      h[1][i] = (i < 3) ? 8'(i + 1) : 8'd0;
    end
    sv[0] = 1'b0; sv[1] = 1'b0;
    smp[0] = 8'd0; smp[1] = 8'd0;
    exp_wp[0] = 3'd0; exp_wp[1] = 3'd0;
    rst_n = 1'b0;

    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ctl", 32'({busy_w[d], rdy[d], wr_en_w[d], clr_w[d], mid_w[d], yv_w[d]}),
          32'(6'b100000));
      chk("rst_y_out", 32'(y_w[d]), 32'd0);
`ifdef FIR_SEQ_OVERRUN_EN
      chk("rst_overrun", 32'(ovr_w[d]), 32'd0);
`endif
    end

    @(negedge clk);
    rst_n = 1'b1;
    init_seq();

    // Impulse on N_TAPS=8 with sample_valid held high throughout: back-to-back
    // accepts every P+2 cycles, write pointer walks 0..7 then wraps to 0.
    for (int i = 0; i < 9; i++) send(0, t1[i].smp, t1[i].y, 1'b1);
    sv[0] = 1'b0;
    @(negedge clk);
    #1;
    chk("y_valid_single", 32'({yv_w[0], busy_w[0]}), 32'(2'b00));
`ifdef FIR_SEQ_OVERRUN_EN
    chk("overrun_set", 32'(ovr_w[0]), 32'd1);
`endif

    // Impulse on N_TAPS=5, valid dropped after each accept.
    for (int i = 0; i < 6; i++) send(1, t2[i].smp, t2[i].y, 1'b0);
`ifdef FIR_SEQ_OVERRUN_EN
    chk("overrun_quiet", 32'(ovr_w[1]), 32'd0);
    chk("overrun_sticky", 32'(ovr_w[0]), 32'd1);
`endif

    // Dirty the N_TAPS=8 history, then reset during the second ACCUM cycle.
    send(0, 8'd7, 8'd7, 1'b0);
    send(0, 8'd9, 8'd23, 1'b0);
    sv[0] = 1'b1;
    smp[0] = 8'd5;
    #1;
    chk("abort_accept", 32'({rdy[0], wa_w[0]}), 32'({1'b1, exp_wp[0]}));
    @(negedge clk);
    sv[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_rst_ctl", 32'({busy_w[0], rdy[0], yv_w[0], wr_en_w[0], clr_w[0]}),
        32'(5'b10000));
    @(negedge clk);
    rst_n = 1'b1;
    init_seq();
`ifdef FIR_SEQ_OVERRUN_EN
    chk("overrun_cleared", 32'(ovr_w[0]), 32'd0);
`endif
    // Flushed history: old 7 and 9 must not contribute.
    send(0, 8'd3, 8'd3, 1'b0);
    send(0, 8'd0, 8'd6, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
